// File: rtl/zacore_common.sv
// Shared types for the zacore memory subsystem: arbiter FSM states and
// the latched memory request payload.
package zacore_common;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GNT_FETCH  = 2'd1,
        GNT_LSU    = 2'd2,
        FLUSH_WAIT = 2'd3
    } mem_arb_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/zacore_mem_arbiter.sv
// Two-requester (instruction fetch / LSU) arbiter onto a single memory port.
// LSU has priority but is limited to MAX_LSU_BURST consecutive grants while fetch waits.
module zacore_mem_arbiter
    import zacore_common::*;
#(
    parameter int MAX_LSU_BURST = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_fetch_req,
    input  logic [31:0] i_fetch_addr,
    input  logic        i_fetch_flush,
    output logic        o_fetch_ack,
    output logic [31:0] o_fetch_data,

    input  logic        i_lsu_req,
    input  logic        i_lsu_we,
    input  logic [3:0]  i_lsu_be,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    output logic        o_lsu_ack,
    output logic [31:0] o_lsu_rdata,

    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_LSU_BURST);

    mem_arb_state_t state_q;
    mem_arb_state_t state_d;
    mem_req_t       payload_q;
    logic [3:0]     lsu_streak;

    logic fetch_ok;
    logic grant_lsu;
    logic grant_fetch;

    always_comb begin
        fetch_ok    = i_fetch_req && !i_fetch_flush;
        grant_lsu   = i_lsu_req && (!fetch_ok || (lsu_streak < BURST_MAX));
        grant_fetch = fetch_ok && !grant_lsu;

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_lsu)
                    state_d = GNT_LSU;
                else if (grant_fetch)
                    state_d = GNT_FETCH;
            end
            GNT_LSU: begin
                if (i_mem_ack)
                    state_d = IDLE;
            end
            GNT_FETCH: begin
                if (i_mem_ack)
                    state_d = IDLE;
                else if (i_fetch_flush)
                    state_d = FLUSH_WAIT;
            end
            FLUSH_WAIT: begin
                if (i_mem_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            payload_q  <= '0;
            lsu_streak <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (grant_lsu) begin
                    payload_q <= '{we: i_lsu_we, be: i_lsu_be,
                                   addr: i_lsu_addr, wdata: i_lsu_wdata};
                    if (i_fetch_req && (lsu_streak < BURST_MAX))
                        lsu_streak <= lsu_streak + 4'd1;
                end else if (grant_fetch) begin
                    payload_q  <= '{we: 1'b0, be: 4'hF,
                                    addr: i_fetch_addr, wdata: '0};
                    lsu_streak <= '0;
                end
            end
        end
    end

    // Acks are also held off while reset is asserted so an abandoned
    // transaction can never complete to its requester.
    always_comb begin
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_be     = '0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_fetch_ack  = 1'b0;
        o_fetch_data = '0;
        o_lsu_ack    = 1'b0;
        o_lsu_rdata  = '0;

        if (state_q != IDLE) begin
            o_mem_req   = 1'b1;
            o_mem_we    = payload_q.we;
            o_mem_be    = payload_q.be;
            o_mem_addr  = payload_q.addr;
            o_mem_wdata = payload_q.wdata;
        end

        if (i_rst && i_mem_ack) begin
            if (state_q == GNT_LSU) begin
                o_lsu_ack   = 1'b1;
                o_lsu_rdata = i_mem_rdata;
            end else if (state_q == GNT_FETCH && !i_fetch_flush) begin
                o_fetch_ack  = 1'b1;
                o_fetch_data = i_mem_rdata;
            end
        end
    end

endmodule

// File: doc/zacore_mem_arbiter.md
ZACORE_MEM_ARBITER -- requirements
Module: zacore_mem_arbiter

Interface
REQ-001 Parameter MAX_LSU_BURST, default 4: max consecutive LSU grants while fetch waits (range 1-15).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  synchronous, active-low reset.
REQ-004 i_fetch_req  input  1  fetch request; held high until o_fetch_ack.
REQ-005 i_fetch_addr  input  32  fetch word address.
REQ-006 i_fetch_flush  input  1  discard in-flight/pending fetch.
REQ-007 o_fetch_ack  output  1  fetch data valid this cycle.
REQ-008 o_fetch_data  output  32  instruction word.
REQ-009 i_lsu_req  input  1  load/store request; held until o_lsu_ack.
REQ-010 i_lsu_we  input  1  1 = store.
REQ-011 i_lsu_be  input  4  store byte enables.
REQ-012 i_lsu_addr  input  32  data address.
REQ-013 i_lsu_wdata  input  32  store data.
REQ-014 o_lsu_ack  output  1  LSU transaction complete this cycle.
REQ-015 o_lsu_rdata  output  32  load data.
REQ-016 o_mem_req, o_mem_we  output  1 each  memory port request, write strobe.
REQ-017 o_mem_be  output  4; o_mem_addr, o_mem_wdata  output  32 each  memory port payload.
REQ-018 i_mem_ack  input  1; i_mem_rdata  input  32  memory completion and read data.

Function
REQ-019 FSM states SHALL be IDLE, GNT_FETCH, GNT_LSU, FLUSH_WAIT.
REQ-020 In IDLE, a winning request SHALL be latched (we/be/addr/wdata; fetch forces we=0, be=4'hF) and the state SHALL move to its grant state; o_mem_req asserts the next cycle.
REQ-021 Arbitration: LSU alone -> LSU; fetch alone -> fetch; both -> LSU if lsu_streak < MAX_LSU_BURST, else fetch.
REQ-022 lsu_streak SHALL increment on each LSU grant made while i_fetch_req is high, saturate at MAX_LSU_BURST, and clear on any fetch grant.
REQ-023 In grant states, o_mem_req SHALL be 1 and o_mem_* SHALL present the latched payload, stable until i_mem_ack.
REQ-024 On i_mem_ack in GNT_LSU: o_lsu_ack=1 and o_lsu_rdata=i_mem_rdata combinationally that cycle; next state IDLE.
REQ-025 On i_mem_ack in GNT_FETCH with i_fetch_flush=0: o_fetch_ack=1, o_fetch_data=i_mem_rdata same cycle; next state IDLE.
REQ-026 i_fetch_flush in GNT_FETCH without i_mem_ack SHALL move to FLUSH_WAIT; o_mem_req stays 1 (transaction not aborted).
REQ-027 i_fetch_flush coincident with i_mem_ack in GNT_FETCH or FLUSH_WAIT SHALL suppress o_fetch_ack; next state IDLE.
REQ-028 In FLUSH_WAIT, o_fetch_ack SHALL remain 0; i_mem_ack returns to IDLE.
REQ-029 i_fetch_flush in IDLE SHALL exclude fetch from that cycle's arbitration.
REQ-030 Minimum spacing: one IDLE cycle between transactions; peak throughput one transaction per 2 cycles + memory latency.
REQ-031 o_fetch_ack and o_lsu_ack SHALL never be 1 in the same cycle; at most one memory transaction outstanding.
REQ-032 When not acking, o_fetch_data/o_lsu_rdata SHALL be 0; o_mem_* SHALL be 0 in IDLE.

Reset
REQ-033 While i_rst=0 at an edge: state IDLE, lsu_streak 0, latched payload 0; all outputs 0 the following cycle.
REQ-034 Reset mid-transaction SHALL abandon it without acking any requester; a late i_mem_ack in IDLE SHALL be ignored.

Structure
REQ-035 Enum mem_arb_state_t and struct mem_req_t {we, be[3:0], addr[31:0], wdata[31:0]} SHALL live in package zacore_common.
REQ-036 No sub-module; FSM, streak counter and payload register live in zacore_mem_arbiter.

Verification
REQ-037 Fetch alone, addr 0x0000_0100, mem ack after 2 cycles with 0x0000_0013 -> o_mem_req on cycles 1-3, o_fetch_ack with data 0x13 on cycle 3.
REQ-038 Fetch and LSU continuously requesting, MAX_LSU_BURST=4, single-cycle memory -> grant order L,L,L,L,F,L,L,L,L,F.
REQ-039 LSU store addr 0x2000, be 4'b0011, wdata 0xDEAD_BEEF -> o_mem_we=1, be=0011, addr/wdata match until ack; o_lsu_ack 1 cycle.
REQ-040 Fetch granted, flush 1 cycle later, mem ack 3 cycles later -> FLUSH_WAIT, no o_fetch_ack, IDLE after ack.
REQ-041 i_rst=0 in GNT_LSU, then i_mem_ack -> no o_lsu_ack, o_mem_req 0, state IDLE, lsu_streak 0.
